// File: rtl/ov7670_pkg.sv
// Shared SCCB/OV7670 definitions: FSM states, frame geometry and helpers.
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_STOP  = 3'd3,
        ST_GUARD = 3'd4
    } sccb_state_t;

    localparam int unsigned SCCB_BITS_PER_PHASE = 9;
    localparam int unsigned SCCB_PHASES         = 3;
    localparam int unsigned SCCB_FRAME_BITS     = SCCB_BITS_PER_PHASE * SCCB_PHASES;
    localparam int unsigned SCCB_START_Q        = 2;
    localparam int unsigned SCCB_STOP_Q         = 3;
    localparam int unsigned SCCB_GUARD_Q        = 4;
    localparam logic [7:0]  OV7670_WR_ID        = 8'h42;

    // Serialised write frame: each byte is followed by a released 9th (ACK) bit.
    function automatic logic [SCCB_FRAME_BITS-1:0] sccb_frame(
        input logic [7:0] id,
        input logic [7:0] addr,
        input logic [7:0] data
    );
        return {id, 1'b1, addr, 1'b1, data, 1'b1};
    endfunction

    // True for the 9th bit of each phase (bit indices 8, 17, 26).
    function automatic logic sccb_is_ack_bit(input logic [4:0] bit_idx);
        return (32'(bit_idx) % SCCB_BITS_PER_PHASE) == (SCCB_BITS_PER_PHASE - 1);
    endfunction

endpackage

// File: rtl/sccb_quarter_tick.sv
// Quarter-SCL-period divider: one-cycle tick every QUARTER_DIV enabled cycles.
module sccb_quarter_tick #(
    parameter int unsigned QUARTER_DIV = 60
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned   CW   = $clog2(QUARTER_DIV);
    localparam logic [CW-1:0] TERM = CW'(QUARTER_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..QUARTER_DIV-1 while enabled; clear restarts the first quarter.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= (cnt == TERM) ? '0 : cnt + CW'(1);
        end
    end

    assign o_tick = i_en && (cnt == TERM);

endmodule

// File: rtl/sccb_writer.sv
// SCCB write-only master: START, 27-bit ID/addr/data frame, STOP, guard gap.
module sccb_writer #(
    parameter int unsigned QUARTER_DIV = 60
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr_en,
    input  logic [7:0] i_slave_id,
    input  logic [7:0] i_reg_addr,
    input  logic [7:0] i_reg_data,
    output logic       o_wr_done,
    output logic       o_busy,
    output logic       o_ack_err,
    output logic       o_sclk,
    inout  wire        io_sda
);

    import ov7670_pkg::*;

    localparam logic [1:0] START_LAST_Q = 2'(SCCB_START_Q - 1);
    localparam logic [1:0] STOP_LAST_Q  = 2'(SCCB_STOP_Q - 1);
    localparam logic [1:0] GUARD_LAST_Q = 2'(SCCB_GUARD_Q - 1);
    localparam logic [4:0] LAST_BIT     = 5'(SCCB_FRAME_BITS - 1);

    sccb_state_t                state, state_n;
    logic [1:0]                 qcnt, qcnt_n;
    logic [4:0]                 bitcnt, bitcnt_n;
    logic [SCCB_FRAME_BITS-1:0] shreg, shreg_n;
    logic                       busy, busy_n;
    logic                       ack_err, ack_err_n;
    logic                       accept;
    logic                       tick;
    logic                       wr_done;
    logic                       sclk;
    logic                       sda_oe;

    sccb_quarter_tick #(
        .QUARTER_DIV (QUARTER_DIV)
    ) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (busy),
        .i_clr  (accept),
        .o_tick (tick)
    );

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            qcnt    <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            busy    <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            state   <= state_n;
            qcnt    <= qcnt_n;
            bitcnt  <= bitcnt_n;
            shreg   <= shreg_n;
            busy    <= busy_n;
            ack_err <= ack_err_n;
        end
    end

    // Next-state, quarter/bit sequencing and bus line decode.
    always_comb begin
        state_n   = state;
        qcnt_n    = qcnt;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        busy_n    = busy;
        ack_err_n = ack_err;
        accept    = 1'b0;
        wr_done   = 1'b0;
        sclk      = 1'b1;
        sda_oe    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (i_wr_en) begin
                    accept    = 1'b1;
                    shreg_n   = sccb_frame(i_slave_id, i_reg_addr, i_reg_data);
                    ack_err_n = 1'b0;
                    busy_n    = 1'b1;
                    qcnt_n    = '0;
                    bitcnt_n  = '0;
                    state_n   = ST_START;
                end
            end

            ST_START: begin
                sda_oe = (qcnt == 2'd1);
                if (tick) begin
                    if (qcnt == START_LAST_Q) begin
                        qcnt_n  = '0;
                        state_n = ST_SHIFT;
                    end else begin
                        qcnt_n = qcnt + 2'd1;
                    end
                end
            end

            ST_SHIFT: begin
                // SCL low for q0/q1, high for q2/q3; SDA follows the frame MSB.
                sclk   = qcnt[1];
                sda_oe = !shreg[SCCB_FRAME_BITS-1];
                if (tick) begin
                    qcnt_n = qcnt + 2'd1;
                    if ((qcnt == 2'd2) && sccb_is_ack_bit(bitcnt) && (io_sda == 1'b1)) begin
                        ack_err_n = 1'b1;
                    end
                    if (qcnt == 2'd3) begin
                        shreg_n = {shreg[SCCB_FRAME_BITS-2:0], 1'b0};
                        if (bitcnt == LAST_BIT) begin
                            bitcnt_n = '0;
                            state_n  = ST_STOP;
                        end else begin
                            bitcnt_n = bitcnt + 5'd1;
                        end
                    end
                end
            end

            ST_STOP: begin
                sclk   = (qcnt != 2'd0);
                sda_oe = (qcnt != STOP_LAST_Q);
                if (tick) begin
                    if (qcnt == STOP_LAST_Q) begin
                        wr_done = 1'b1;
                        qcnt_n  = '0;
                        state_n = ST_GUARD;
                    end else begin
                        qcnt_n = qcnt + 2'd1;
                    end
                end
            end

            ST_GUARD: begin
                if (tick) begin
                    if (qcnt == GUARD_LAST_Q) begin
                        qcnt_n  = '0;
                        busy_n  = 1'b0;
                        state_n = ST_IDLE;
                    end else begin
                        qcnt_n = qcnt + 2'd1;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign o_wr_done = wr_done;
    assign o_busy    = busy;
    assign o_ack_err = ack_err;
    assign o_sclk    = sclk;
    assign io_sda    = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_sccb_writer.sv
// Directed self-checking bench for sccb_writer with QUARTER_DIV=2.
module tb_sccb_writer;

    localparam int unsigned QD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] slave_id;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       wr_done;
    logic       busy;
    logic       ack_err;
    logic       sclk;
    wire        io_sda;
    logic       slave_drv = 1'b0;
    logic       ack_en    = 1'b0;

    pullup (io_sda);
    assign io_sda = slave_drv ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    sccb_writer #(
        .QUARTER_DIV (QD)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_en    (wr_en),
        .i_slave_id (slave_id),
        .i_reg_addr (reg_addr),
        .i_reg_data (reg_data),
        .o_wr_done  (wr_done),
        .o_busy     (busy),
        .o_ack_err  (ack_err),
        .o_sclk     (sclk),
        .io_sda     (io_sda)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor and ACK-driving slave, sampled mid-cycle.
    logic        prev_scl  = 1'b1;
    logic        prev_sda  = 1'b1;
    logic        prev_busy = 1'b0;
    logic        sda_s;
    int          n_start = 0, n_stop = 0, n_fall = 0, n_done = 0;
    int          fall_cnt = 0, rise_cnt = 0;
    int          start_cyc = 0, done_cyc = 0, busy_fall_cyc = 0, done_rise_cnt = 0;
    logic [26:0] frame = '0;
    logic [26:0] done_frame = '0;
    logic        done_ack_err = 1'b0;

    always @(negedge clk) begin
        sda_s = io_sda;
        if (prev_scl && sclk && prev_sda && !sda_s) begin
            n_start++;
            start_cyc = cyc;
            fall_cnt  = 0;
            rise_cnt  = 0;
            frame     = '0;
        end
        if (prev_scl && sclk && !prev_sda && sda_s) n_stop++;
        if (prev_scl && !sclk) begin
            n_fall++;
            fall_cnt++;
        end
        if (!prev_scl && sclk) begin
            if (rise_cnt < 27) frame[26-rise_cnt] = sda_s;
            rise_cnt++;
        end
        if (wr_done) begin
            n_done++;
            done_cyc      = cyc;
            done_frame    = frame;
            done_ack_err  = ack_err;
            done_rise_cnt = rise_cnt;
        end
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        slave_drv = ack_en && (fall_cnt == 9 || fall_cnt == 18 || fall_cnt == 27);
        prev_scl  = sclk;
        prev_sda  = sda_s;
        prev_busy = busy;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int prev, input int budget);
        int k = 0;
        while (n_done == prev && k < budget) begin
            tick();
            k++;
        end
        check_val("done_seen", 32'(n_done != prev), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check_val("busy_drop", 32'(busy), 32'd0);
    endtask

    task automatic start_txn(input logic [7:0] id, input logic [7:0] a, input logic [7:0] d,
                             output int t0);
        slave_id = id;
        reg_addr = a;
        reg_data = d;
        wr_en    = 1'b1;
        t0       = cyc;
        tick();
        check_val("busy_after_accept", 32'(busy), 32'd1);
        wr_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, nd, fall0, viol, stop0, r_cyc;

        rst = 1'b1; wr_en = 1'b0; slave_id = '0; reg_addr = '0; reg_data = '0;
        repeat (3) tick();
        check_val("rst_sclk",  32'(sclk),    32'd1);
        check_val("rst_sda",   32'(io_sda),  32'd1);
        check_val("rst_busy",  32'(busy),    32'd0);
        check_val("rst_done",  32'(wr_done), 32'd0);
        check_val("rst_ackerr", 32'(ack_err), 32'd0);
        rst = 1'b0;

        // Idle bus for 1000 cycles with no request.
        viol = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (sclk !== 1'b1 || io_sda !== 1'b1 || busy !== 1'b0 || wr_done !== 1'b0) viol++;
        end
        check_val("idle_quiet", 32'(viol), 32'd0);

        // Write with an acknowledging slave.
        ack_en = 1'b1;
        nd = n_done; stop0 = n_stop;
        start_txn(8'h42, 8'h12, 8'h80, t0);
        wait_done(nd, 400);
        check_val("ack_done_cyc",  32'(done_cyc - t0),  32'd226);
        check_val("ack_start_cyc", 32'(start_cyc - t0), 32'd3);
        check_val("ack_frame",     32'(done_frame), 32'({8'h42, 1'b0, 8'h12, 1'b0, 8'h80, 1'b0}));
        check_val("ack_rises",     32'(done_rise_cnt), 32'd28);
        check_val("ack_stop_seen", 32'(n_stop - stop0), 32'd1);
        check_val("ack_err_clear", 32'(done_ack_err), 32'd0);
        tick();
        check_val("done_one_cycle", 32'(wr_done), 32'd0);
        wait_idle(40);
        check_val("busy_fall_cyc", 32'(busy_fall_cyc - t0), 32'd235);
        check_val("ack_done_count", 32'(n_done - nd), 32'd1);

        // Same write with no slave: every 9th bit reads high.
        ack_en = 1'b0;
        nd = n_done;
        start_txn(8'h42, 8'h12, 8'h80, t0);
        wait_done(nd, 400);
        check_val("nack_done_cyc", 32'(done_cyc - t0), 32'd226);
        check_val("nack_frame",    32'(done_frame), 32'({8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1}));
        check_val("nack_err",      32'(done_ack_err), 32'd1);
        wait_idle(40);
        check_val("nack_err_hold", 32'(ack_err), 32'd1);

        // Back-to-back with i_wr_en held high; inputs change during guard.
        ack_en = 1'b1;
        slave_id = 8'h42; reg_addr = 8'h12; reg_data = 8'h80; wr_en = 1'b1;
        nd = n_done;
        t0 = cyc;
        tick();
        check_val("b2b_busy", 32'(busy), 32'd1);
        check_val("accept_clears_err", 32'(ack_err), 32'd0);
        wait_done(nd, 400);
        check_val("b2b_first_done", 32'(done_cyc - t0), 32'd226);
        t1 = done_cyc + 9;
        fall0 = n_fall;
        viol = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) begin
                reg_addr = 8'h11;
                reg_data = 8'h3A;
            end
            if (sclk !== 1'b1 || busy !== 1'b1) viol++;
        end
        check_val("guard_quiet", 32'(viol), 32'd0);
        check_val("guard_no_fall", 32'(n_fall - fall0), 32'd0);
        tick();
        check_val("guard_end_idle", 32'(busy), 32'd0);
        tick();
        check_val("b2b_reaccept", 32'(busy), 32'd1);
        wr_en = 1'b0;
        nd = n_done;
        wait_done(nd, 400);
        check_val("b2b_second_done", 32'(done_cyc - t1), 32'd226);
        check_val("b2b_frame", 32'(done_frame), 32'({8'h42, 1'b0, 8'h11, 1'b0, 8'h3A, 1'b0}));
        wait_idle(40);

        // Input data changes mid-transaction must not leak into the frame.
        nd = n_done;
        start_txn(8'h42, 8'h12, 8'h80, t0);
        while (cyc < t0 + 50) tick();
        reg_data = 8'hFF;
        wait_done(nd, 400);
        check_val("latched_frame", 32'(done_frame), 32'({8'h42, 1'b0, 8'h12, 1'b0, 8'h80, 1'b0}));
        wait_idle(40);

        // Reset during the address byte, then restart with a held request.
        ack_en = 1'b0;
        nd = n_done;
        start_txn(8'h42, 8'h12, 8'h80, t0);
        while (cyc < t0 + 90) tick();
        rst = 1'b1; wr_en = 1'b1;
        slave_id = 8'h42; reg_addr = 8'h3A; reg_data = 8'h5C;
        tick();
        check_val("rst_mid_sclk", 32'(sclk),    32'd1);
        check_val("rst_mid_sda",  32'(io_sda),  32'd1);
        check_val("rst_mid_busy", 32'(busy),    32'd0);
        check_val("rst_mid_done", 32'(wr_done), 32'd0);
        tick();
        check_val("rst_wins", 32'(busy), 32'd0);
        rst = 1'b0;
        r_cyc = cyc;
        tick();
        check_val("post_rst_accept", 32'(busy), 32'd1);
        wr_en = 1'b0;
        wait_done(nd, 400);
        check_val("post_rst_no_stale_done", 32'(n_done - nd), 32'd1);
        check_val("post_rst_done_cyc",  32'(done_cyc - r_cyc),  32'd226);
        check_val("post_rst_start_cyc", 32'(start_cyc - r_cyc), 32'd3);
        check_val("post_rst_frame", 32'(done_frame), 32'({8'h42, 1'b1, 8'h3A, 1'b1, 8'h5C, 1'b1}));
        check_val("post_rst_err", 32'(done_ack_err), 32'd1);
        wait_idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
